vsad_accum_seq: RTL and testbench

- Sequencer wrapped around one vector_scale_add (vsad) instance. It computes the weighted sigma-point mean, mean = sum over i of w_i * X_i, across N_POINTS vectors.
- It accepts (weight, vector) pairs on a valid/ready stream and issues them to vsad, supplying its running Q32.32 accumulator as Y.
- It captures vsad's P back into that accumulator. Once all points are summed, it emits the mean requantised to Q16.16.
- Sits between the sigma-point generator (upstream) and vsad (downstream/feedback).

---
 rtl/vsad_accum_seq.sv | 163 ++++++++++++++++
 tb/tb_vsad_accum_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vsad_accum_seq.sv
// Sequencer around one vector_scale_add unit: accumulates sum(w_i * X_i) over
// N_POINTS vectors in Q32.32 and emits the mean requantised to Q16.16.
module vsad_accum_seq #(
    parameter int unsigned LENGTH       = 5,
    parameter int unsigned N_POINTS     = 11,
    parameter int unsigned VSAD_LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     sclr,
    input  logic                     ce,
    input  logic                     start,
    input  logic                     pt_valid,
    output logic                     pt_ready,
    input  logic [31:0]              pt_w,
    input  logic [LENGTH*32-1:0]     pt_X,
    output logic [31:0]              vsad_w,
    output logic [LENGTH*32-1:0]     vsad_X,
    output logic [LENGTH*64-1:0]     vsad_Y,
    input  logic [LENGTH*64-1:0]     vsad_P,
    output logic [LENGTH*32-1:0]     mean,
    output logic                     mean_valid,
    output logic                     busy
);

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 64;
    localparam int unsigned CNT_W  = (N_POINTS > 1) ? $clog2(N_POINTS + 1) : 1;
    localparam int unsigned WAIT_W = (VSAD_LATENCY > 1) ? $clog2(VSAD_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_clear;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_done;

    logic [LENGTH*AW-1:0]    r_acc;
    logic [CNT_W-1:0]        r_pt_cnt;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [DW-1:0]           r_vsad_w;
    logic [LENGTH*DW-1:0]    r_vsad_x;
    logic [LENGTH*AW-1:0]    r_vsad_y;
    logic [LENGTH*DW-1:0]    r_mean;
    logic                    r_mean_valid;
    logic [LENGTH*DW-1:0]    w_mean_q;

    // State register
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pt_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (r_pt_cnt == CNT_W'(N_POINTS - 1)) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: issue registers, wait countdown, accumulator capture, mean output
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_acc        <= '0;
            r_pt_cnt     <= '0;
            r_wait_cnt   <= '0;
            r_vsad_w     <= '0;
            r_vsad_x     <= '0;
            r_vsad_y     <= '0;
            r_mean       <= '0;
            r_mean_valid <= 1'b0;
        end else if (ce) begin
            if (w_clear) begin
                r_acc    <= '0;
                r_pt_cnt <= '0;
            end
            if (w_accept) begin
                r_vsad_w   <= pt_w;
                r_vsad_x   <= pt_X;
                r_vsad_y   <= r_acc;
                r_wait_cnt <= WAIT_W'(VSAD_LATENCY);
            end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
            end
            if (w_capture) begin
                r_acc    <= vsad_P;
                r_pt_cnt <= r_pt_cnt + CNT_W'(1);
            end
            r_mean_valid <= w_done;
            if (w_done) begin
                r_mean <= w_mean_q;
            end
        end
    end

    // Q32.32 -> Q16.16 per lane: round half up, saturate instead of wrapping
    for (genvar k = 0; k < int'(LENGTH); k++) begin : g_lane
        logic [16:0] w_hi;
        logic [32:0] w_sum;
        logic        w_hi_eq;
        logic [31:0] w_q;

        assign w_hi    = r_acc[AW*k+47 +: 17];
        assign w_hi_eq = (&w_hi) | ~(|w_hi);
        assign w_sum   = {r_acc[AW*k+47], r_acc[AW*k+16 +: 32]} + 33'(r_acc[AW*k+15]);

        always_comb begin
            w_q = w_sum[31:0];
            if (!w_hi_eq) begin
                w_q = r_acc[AW*k+63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else if (w_sum[32] != w_sum[31]) begin
                w_q = 32'h7FFF_FFFF;
            end
        end

        assign w_mean_q[DW*k +: DW] = w_q;
    end

    assign pt_ready   = ce && (r_state == S_ISSUE);
    assign busy       = (r_state != S_IDLE);
    assign vsad_w     = r_vsad_w;
    assign vsad_X     = r_vsad_x;
    assign vsad_Y     = r_vsad_y;
    assign mean       = r_mean;
    assign mean_valid = r_mean_valid;

endmodule

// File: tb/tb_vsad_accum_seq.sv
// Bench for vsad_accum_seq with a behavioural vsad (P = w*X + Y after LAT edges).
// N_POINTS is 3; shorter sums are padded with zero-weight points.
module tb_vsad_accum_seq;

    localparam int unsigned LEN = 2;
    localparam int unsigned NP  = 3;
    localparam int unsigned LAT = 6;

    logic                 clk = 1'b0;
    logic                 sclr;
    logic                 ce;
    logic                 start;
    logic                 pt_valid;
    logic                 pt_ready;
    logic [31:0]          pt_w;
    logic [LEN*32-1:0]    pt_X;
    logic [31:0]          vsad_w;
    logic [LEN*32-1:0]    vsad_X;
    logic [LEN*64-1:0]    vsad_Y;
    logic [LEN*64-1:0]    vsad_P;
    logic [LEN*32-1:0]    mean;
    logic                 mean_valid;
    logic                 busy;

    always #5 clk = ~clk;

    vsad_accum_seq #(
        .LENGTH      (LEN),
        .N_POINTS    (NP),
        .VSAD_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .sclr      (sclr),
        .ce        (ce),
        .start     (start),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_w      (pt_w),
        .pt_X      (pt_X),
        .vsad_w    (vsad_w),
        .vsad_X    (vsad_X),
        .vsad_Y    (vsad_Y),
        .vsad_P    (vsad_P),
        .mean      (mean),
        .mean_valid(mean_valid),
        .busy      (busy)
    );

    function automatic logic [LEN*64-1:0] vsad_model(input logic [31:0] w,
                                                     input logic [LEN*32-1:0] x,
                                                     input logic [LEN*64-1:0] y);
        logic [LEN*64-1:0] res;
        logic [63:0]       we;
        logic [63:0]       xe;
        res = '0;
        for (int k = 0; k < int'(LEN); k++) begin
            we = {{32{w[31]}}, w};
            xe = {{32{x[32*k+31]}}, x[32*k +: 32]};
            res[64*k +: 64] = we * xe + y[64*k +: 64];
        end
        return res;
    endfunction

    logic [LEN*64-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (ce) begin
            for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= vsad_model(vsad_w, vsad_X, vsad_Y);
        end
    end
    assign vsad_P = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [NP-1:0][31:0] w;
        logic [NP-1:0][31:0] x0;
        logic [NP-1:0][31:0] x1;
        logic [31:0]         e0;
        logic [31:0]         e1;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] sb [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_vec(input int idx,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] e0, input logic [31:0] e1);
        vecs[idx].w[0]  = w0; vecs[idx].w[1]  = w1; vecs[idx].w[2]  = w2;
        vecs[idx].x0[0] = a0; vecs[idx].x0[1] = a1; vecs[idx].x0[2] = a2;
        vecs[idx].x1[0] = b0; vecs[idx].x1[1] = b1; vecs[idx].x1[2] = b2;
        vecs[idx].e0    = e0;
        vecs[idx].e1    = e1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain run; 1: ce stall + start pulse mid-WAIT; 2: sclr mid-WAIT
    task automatic run_vec(input int idx, input int mode);
        vec_t        v;
        int          c_prev;
        int          c_acc;
        int          n;
        int          exp_gap;
        bit          got;
        logic [63:0] exp;
        v      = vecs[idx];
        c_prev = 0;
        if (mode != 2) sb.push_back({v.e1, v.e0});
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mode == 1) begin
            ce = 1'b0;
            #1;
            chk("ready_ce_low", 64'(pt_ready), 64'd0);
            ce = 1'b1;
            #1;
        end
        for (int p = 0; p < int'(NP); p++) begin
            pt_valid = 1'b1;
            pt_w     = v.w[p];
            pt_X     = {v.x1[p], v.x0[p]};
            n = 0;
            while (!pt_ready && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("ready_v%0d_p%0d", idx, p), 64'(pt_ready), 64'd1);
            tick();
            c_acc = cyc;
            if (p > 0) begin
                exp_gap = int'(LAT) + 2 + ((mode == 1 && p == 1) ? 3 : 0);
                chk($sformatf("gap_v%0d_p%0d", idx, p), 64'(c_acc - c_prev), 64'(exp_gap));
            end
            c_prev = c_acc;
            if (p == 0 && mode == 1) begin
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
                ce    = 1'b0;
                repeat (3) tick();
                ce = 1'b1;
            end
            if (p == 0 && mode == 2) begin
                tick();
                sclr = 1'b1;
                tick();
                sclr     = 1'b0;
                pt_valid = 1'b0;
                chk("sclr_busy", 64'(busy), 64'd0);
                chk("sclr_ready", 64'(pt_ready), 64'd0);
                chk("sclr_mean", 64'(mean), 64'd0);
                got = 1'b0;
                repeat (30) begin
                    tick();
                    if (mean_valid) got = 1'b1;
                end
                chk("sclr_no_mean_valid", 64'(got), 64'd0);
                return;
            end
        end
        pt_valid = 1'b0;
        n = 0;
        while (!mean_valid && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("mv_seen_v%0d", idx), 64'(mean_valid), 64'd1);
        if (mean_valid) begin
            chk($sformatf("mv_lat_v%0d", idx), 64'(cyc - c_prev), 64'(LAT + 2));
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp = sb.pop_front();
                chk($sformatf("mean_v%0d", idx), 64'(mean), exp);
            end
            tick();
            chk($sformatf("mv_pulse_v%0d", idx), 64'(mean_valid), 64'd0);
            chk($sformatf("idle_v%0d", idx), 64'(busy), 64'd0);
        end
    endtask

    initial begin
        set_vec(0, 32'h0000_8000, 32'h0, 32'h0,
                   32'h0004_8000, 32'h0, 32'h0,
                   32'hfff1_8000, 32'h0, 32'h0,
                   32'h0002_4000, 32'hfff8_c000);
        set_vec(1, 32'h0000_4000, 32'h0001_0000, 32'h0000_8000,
                   32'hfff1_8000, 32'h0001_0000, 32'h0019_c000,
                   32'h000e_8000, 32'hffff_0000, 32'hffe6_4000,
                   32'h000a_4000, 32'hfff5_c000);
        set_vec(2, 32'h7fff_0000, 32'h7fff_0000, 32'h0,
                   32'h7fff_0000, 32'h7fff_0000, 32'h0,
                   32'h8001_0000, 32'h8001_0000, 32'h0,
                   32'h7fff_ffff, 32'h8000_0000);
        set_vec(3, 32'h0000_0001, 32'h0, 32'h0,
                   32'h0000_8000, 32'h0, 32'h0,
                   32'h0000_4000, 32'h0, 32'h0,
                   32'h0000_0001, 32'h0000_0000);
        set_vec(4, 32'h0000_0001, 32'h0, 32'h0,
                   32'hffff_8000, 32'h0, 32'h0,
                   32'hffff_4000, 32'h0, 32'h0,
                   32'h0000_0000, 32'hffff_ffff);
        set_vec(5, 32'h7fff_0000, 32'h0001_0000, 32'h0000_0001,
                   32'h0001_0000, 32'h0000_ffff, 32'h0000_8000,
                   32'h0001_0000, 32'h0000_ffff, 32'h0000_7fff,
                   32'h7fff_ffff, 32'h7fff_ffff);

        sclr     = 1'b1;
        ce       = 1'b1;
        start    = 1'b0;
        pt_valid = 1'b0;
        pt_w     = '0;
        pt_X     = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(pt_ready), 64'd0);
        chk("rst_mean", 64'(mean), 64'd0);
        chk("rst_mean_valid", 64'(mean_valid), 64'd0);
        chk("rst_vsad_w", 64'(vsad_w), 64'd0);
        chk("rst_vsad_y_lo", vsad_Y[63:0], 64'd0);
        sclr = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, 0);
        run_vec(1, 1);
        run_vec(2, 2);
        run_vec(0, 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
